// File: rtl/bnn_dense_engine_if.sv
// Pin-level bundle for bnn_dense_engine: serial weight load, frame handshake
// and result outputs. The controller side owns the engine inputs.
interface bnn_dense_engine_if #(
   parameter int N_IN  = 196,
   parameter int N_OUT = 10
);
   localparam int CNT_W = $clog2(N_IN + 1);
   localparam int CW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   logic              w_valid;
   logic              w_bit;
   logic              w_loaded;
   logic              start;
   logic [N_IN-1:0]   data_in;
   logic              busy;
   logic              done;
   logic [N_OUT-1:0]  act_out;
   logic [CW-1:0]     class_out;
   logic [CNT_W-1:0]  score_out;

   modport master (
      output w_valid, w_bit, start, data_in,
      input  w_loaded, busy, done, act_out, class_out, score_out
   );

   modport slave (
      input  w_valid, w_bit, start, data_in,
      output w_loaded, busy, done, act_out, class_out, score_out
   );
endinterface

// File: rtl/bnn_dense_engine.sv
// Time-multiplexed binary dense layer: XNOR-popcount of a latched input
// vector against N_OUT stored weight rows, CHUNK bits per cycle, producing
// binarised activations plus the argmax neuron and its score.
//
// state | meaning
// IDLE  | accepts serial weight bits and frame starts
// ACC   | accumulates one CHUNK of neuron n per cycle
// DONE  | one-cycle completion pulse, results already registered
module bnn_dense_engine #(
   parameter int N_IN   = 196,
   parameter int N_OUT  = 10,
   parameter int CHUNK  = 14,
   parameter int THRESH = 98
) (
   input  logic               clk,
   input  logic               rst,
   bnn_dense_engine_if.slave  bus
);
   localparam int CNT_W = $clog2(N_IN + 1);
   localparam int CW    = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int NC    = N_IN / CHUNK;
   localparam int TOTAL = N_IN * N_OUT;
   localparam int AW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int WW    = $clog2(TOTAL + 1);
   localparam int CHW   = (NC > 1) ? $clog2(NC) : 1;
   localparam int PW    = $clog2(CHUNK + 1);
   localparam int DW    = (N_IN > 1) ? $clog2(N_IN) : 1;

   if (N_IN % CHUNK != 0) begin : g_bad_chunk
      $error("bnn_dense_engine: CHUNK must divide N_IN");
   end
   if (THRESH < 0 || THRESH > N_IN) begin : g_bad_thresh
      $error("bnn_dense_engine: THRESH must lie in 0..N_IN");
   end

   typedef enum logic [1:0] {S_IDLE, S_ACC, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [WW-1:0]      wcnt;
   logic [AW-1:0]      waddr;
   logic               w_loaded_q;
   logic [TOTAL-1:0]   wmem;
   logic [N_IN-1:0]    data_q;
   logic [CW-1:0]      n_q;
   logic [CHW-1:0]     c_q;
   logic [CNT_W-1:0]   acc_q, best_q;
   logic [CW-1:0]      cls_q;
   logic [N_OUT-1:0]   act_q;
   logic [N_OUT-1:0]   act_out_q;
   logic [CW-1:0]      class_out_q;
   logic [CNT_W-1:0]   score_out_q;

   logic               accept, wr_en, last_c, last_n;
   logic [AW-1:0]      rbase;
   logic [DW-1:0]      dbase;
   logic [CHUNK-1:0]   match;
   logic [PW-1:0]      pcnt;
   logic [CNT_W-1:0]   sum, best_nxt;
   logic [CW-1:0]      cls_nxt;
   logic [N_OUT-1:0]   act_nxt;
   logic               ge, take;

   // A start that is accepted wins over a coincident weight bit, so the
   // weights can never change underneath a frame that is about to run.
   assign accept = (state_q == S_IDLE) && bus.start && w_loaded_q;
   assign wr_en  = (state_q == S_IDLE) && bus.w_valid && !accept;
   assign last_c = (c_q == CHW'(NC - 1));
   assign last_n = (n_q == CW'(N_OUT - 1));
   assign waddr  = wcnt[AW-1:0];

   // XNOR-popcount of the current chunk and the neuron-end decisions.
   always_comb begin
      rbase = AW'(int'(n_q) * N_IN + int'(c_q) * CHUNK);
      dbase = DW'(int'(c_q) * CHUNK);
      match = ~(data_q[dbase +: CHUNK] ^ wmem[rbase +: CHUNK]);
      pcnt  = '0;
      for (int i = 0; i < CHUNK; i++) begin
         pcnt = pcnt + PW'(match[i]);
      end
      sum      = acc_q + CNT_W'(pcnt);
      ge       = (sum >= CNT_W'(THRESH));
      take     = (n_q == '0) || (sum > best_q);
      best_nxt = take ? sum : best_q;
      cls_nxt  = take ? n_q : cls_q;
      act_nxt  = act_q;
      act_nxt[n_q] = ge;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = S_ACC;
         S_ACC:   if (last_c && last_n) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Serial weight counter; a bit arriving while loaded restarts at bit 0
   // because the counter already wrapped to zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt       <= '0;
         w_loaded_q <= 1'b0;
      end else if (wr_en) begin
         if (wcnt == WW'(TOTAL - 1)) begin
            wcnt       <= '0;
            w_loaded_q <= 1'b1;
         end else begin
            wcnt       <= wcnt + WW'(1);
            w_loaded_q <= 1'b0;
         end
      end
   end

   // Weight storage is not reset; a reload is required after reset anyway.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) wmem[waddr] <= bus.w_bit;
   end

   // Frame datapath; result outputs only move on the edge entering DONE.
   always_ff @(posedge clk) begin
      if (rst) begin
         n_q         <= '0;
         c_q         <= '0;
         acc_q       <= '0;
         best_q      <= '0;
         cls_q       <= '0;
         act_q       <= '0;
         act_out_q   <= '0;
         class_out_q <= '0;
         score_out_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (accept) begin
                  data_q <= bus.data_in;
                  n_q    <= '0;
                  c_q    <= '0;
                  acc_q  <= '0;
                  best_q <= '0;
                  cls_q  <= '0;
                  act_q  <= '0;
               end
            end
            S_ACC: begin
               if (last_c) begin
                  act_q  <= act_nxt;
                  best_q <= best_nxt;
                  cls_q  <= cls_nxt;
                  acc_q  <= '0;
                  c_q    <= '0;
                  if (last_n) begin
                     n_q         <= '0;
                     act_out_q   <= act_nxt;
                     class_out_q <= cls_nxt;
                     score_out_q <= best_nxt;
                  end else begin
                     n_q <= n_q + CW'(1);
                  end
               end else begin
                  acc_q <= sum;
                  c_q   <= c_q + CHW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy      = (state_q != S_IDLE);
   assign bus.done      = (state_q == S_DONE);
   assign bus.w_loaded  = w_loaded_q;
   assign bus.act_out   = act_out_q;
   assign bus.class_out = class_out_q;
   assign bus.score_out = score_out_q;
endmodule

// File: tb/tb_bnn_dense_engine.sv
// Bench for bnn_dense_engine: default instance checked every cycle against a
// frame-level model, plus a small N_IN=8 instance checked with literals.
module tb_bnn_dense_engine;
   localparam int N_IN   = 196;
   localparam int N_OUT  = 10;
   localparam int CHUNK  = 14;
   localparam int THRESH = 98;
   localparam int TOTAL  = N_IN * N_OUT;
   localparam int NACC   = N_OUT * N_IN / CHUNK;
   localparam int STOTAL = 32;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   bnn_dense_engine_if #(.N_IN(N_IN), .N_OUT(N_OUT)) bif();
   bnn_dense_engine_if #(.N_IN(8), .N_OUT(4)) sif();

   bnn_dense_engine #(.N_IN(N_IN), .N_OUT(N_OUT), .CHUNK(CHUNK), .THRESH(THRESH)) u_dut (
      .clk(clk), .rst(rst), .bus(bif)
   );
   bnn_dense_engine #(.N_IN(8), .N_OUT(4), .CHUNK(2), .THRESH(5)) u_small (
      .clk(clk), .rst(rst), .bus(sif)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- frame-level model of the default instance ------------
   int               cyc = 0;
   bit               m_init = 0;
   bit               m_loaded = 0;
   int               m_cnt = 0;
   logic [TOTAL-1:0] m_w;
   bit               m_active = 0;
   int               m_e0 = 0;
   logic [9:0]       vis_act = '0, pend_act;
   logic [3:0]       vis_cls = '0, pend_cls;
   logic [7:0]       vis_score = '0, pend_score;

   function automatic void model_eval(input logic [N_IN-1:0] d, output logic [9:0] act,
                                      output logic [3:0] cls, output logic [7:0] score);
      int best;
      act = '0; cls = '0; best = 0;
      for (int n = 0; n < N_OUT; n++) begin
         int s;
         s = 0;
         for (int i = 0; i < N_IN; i++)
            if (d[i] == m_w[n*N_IN + i]) s++;
         act[n] = (s >= THRESH);
         if (n == 0 || s > best) begin
            best = s;
            cls  = 4'(n);
         end
      end
      score = 8'(best);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
         m_init = 1; m_loaded = 0; m_cnt = 0; m_active = 0;
         vis_act = '0; vis_cls = '0; vis_score = '0;
      end else if (m_init) begin
         if (m_active && cyc - m_e0 == NACC) begin
            vis_act = pend_act; vis_cls = pend_cls; vis_score = pend_score;
         end
         if (m_active && cyc - m_e0 >= NACC + 2) m_active = 0;
         if (!m_active) begin
            if (bif.start && m_loaded) begin
               m_active = 1;
               m_e0 = cyc;
               model_eval(bif.data_in, pend_act, pend_cls, pend_score);
            end else if (bif.w_valid) begin
               m_w[m_cnt] = bif.w_bit;
               m_cnt++;
               if (m_cnt == TOTAL) begin
                  m_loaded = 1; m_cnt = 0;
               end else begin
                  m_loaded = 0;
               end
            end
         end
      end
   end

   // Cycle-by-cycle comparison, sampled on the falling edge.
   initial forever begin
      @(negedge clk);
      if (m_init) begin
         int t;
         t = cyc - m_e0;
         check("busy", 32'(bif.busy), 32'(m_active && t <= NACC));
         check("done", 32'(bif.done), 32'(m_active && t == NACC));
         check("w_loaded", 32'(bif.w_loaded), 32'(m_loaded));
         check("act_out", 32'(bif.act_out), 32'(vis_act));
         check("class_out", 32'(bif.class_out), 32'(vis_cls));
         check("score_out", 32'(bif.score_out), 32'(vis_score));
      end
   end

   // ---------------- stimulus helpers ------------------------------------
   task automatic load_big(input logic [TOTAL-1:0] p, input logic [N_IN-1:0] d);
      for (int k = 0; k < TOTAL; k++) begin
         bif.w_valid = 1'b1;
         bif.w_bit   = p[k];
         bif.data_in = d;
         bif.start   = ((k >= 100 && k < 104) || k == TOTAL - 1);
         tick();
         if (k == 0) check("w_loaded_drops_first_bit", 32'(bif.w_loaded), 32'd0);
      end
      bif.w_valid = 1'b0;
      bif.start   = 1'b0;
      check("w_loaded_after_load", 32'(bif.w_loaded), 32'd1);
      check("no_busy_during_load", 32'(bif.busy), 32'd0);
   endtask

   task automatic run_big(input logic [N_IN-1:0] d, input bit misuse, output int lat);
      bif.data_in = d;
      bif.start   = 1'b1;
      tick();
      bif.start = 1'b0;
      lat = 1;
      while (!bif.done && lat < 400) begin
         if (misuse) begin
            bif.start   = (lat == 20);
            bif.data_in = (lat == 20) ? ~d : d;
            bif.w_valid = (lat >= 30 && lat < 36);
            bif.w_bit   = 1'b0;
         end
         tick();
         lat++;
      end
      bif.start   = 1'b0;
      bif.w_valid = 1'b0;
      bif.data_in = d;
      // start coinciding with done must be ignored
      bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      check("start_on_done_ignored", 32'(bif.busy), 32'd0);
   endtask

   logic [N_IN-1:0]  dpat;
   logic [TOTAL-1:0] pat;
   logic [STOTAL-1:0] spat;
   logic [7:0]        smask [4];
   int lat;
   int seen_done;

   initial begin
      rst = 1'b1;
      bif.w_valid = 0; bif.w_bit = 0; bif.start = 0; bif.data_in = '0;
      sif.w_valid = 0; sif.w_bit = 0; sif.start = 0; sif.data_in = '0;
      tick(); tick();
      rst = 1'b0;
      check("reset_act", 32'(bif.act_out), 32'd0);
      check("reset_class", 32'(bif.class_out), 32'd0);
      check("reset_score", 32'(bif.score_out), 32'd0);
      check("reset_loaded", 32'(bif.w_loaded), 32'd0);
      check("small_reset_busy", 32'(sif.busy), 32'd0);

      // start before any weights: ignored
      bif.start = 1'b1; tick(); tick(); bif.start = 1'b0;
      check("start_unloaded_ignored", 32'(bif.busy), 32'd0);

      // Pattern A: all ones
      pat = '1;
      dpat = '1;
      load_big(pat, dpat);
      run_big(dpat, 1'b1, lat);
      check("ones_latency", 32'(lat), 32'd141);
      check("ones_act", 32'(bif.act_out), 32'h3FF);
      check("ones_class", 32'(bif.class_out), 32'd0);
      check("ones_score", 32'(bif.score_out), 32'd196);
      check("model_ones_act", 32'(vis_act), 32'h3FF);
      check("model_ones_score", 32'(vis_score), 32'd196);
      check("loaded_kept_after_misuse", 32'(bif.w_loaded), 32'd1);
      run_big(dpat, 1'b0, lat);
      check("ones_undisturbed_latency", 32'(lat), 32'd141);
      check("ones_undisturbed_act", 32'(bif.act_out), 32'h3FF);
      check("ones_undisturbed_class", 32'(bif.class_out), 32'd0);
      check("ones_undisturbed_score", 32'(bif.score_out), 32'd196);

      // Pattern B: neuron 3 equals data, the rest are its complement
      dpat = {14{14'h2A5B}};
      for (int n = 0; n < N_OUT; n++) pat[n*N_IN +: N_IN] = (n == 3) ? dpat : ~dpat;
      load_big(pat, dpat);
      run_big(dpat, 1'b0, lat);
      check("n3_latency", 32'(lat), 32'd141);
      check("n3_act", 32'(bif.act_out), 32'h008);
      check("n3_class", 32'(bif.class_out), 32'd3);
      check("n3_score", 32'(bif.score_out), 32'd196);
      check("model_n3_class", 32'(vis_cls), 32'd3);

      // Small instance: row n matches data in 2n+1 bits
      smask[0] = 8'h01; smask[1] = 8'h07; smask[2] = 8'h1F; smask[3] = 8'h7F;
      for (int n = 0; n < 4; n++) spat[n*8 +: 8] = 8'hA6 ^ ~smask[n];
      for (int k = 0; k < STOTAL; k++) begin
         sif.w_valid = 1'b1; sif.w_bit = spat[k];
         tick();
      end
      sif.w_valid = 1'b0;
      check("small_loaded", 32'(sif.w_loaded), 32'd1);
      sif.data_in = 8'hA6; sif.start = 1'b1;
      tick();
      sif.start = 1'b0;
      lat = 1;
      while (!sif.done && lat < 100) begin
         tick();
         lat++;
      end
      check("small_latency", 32'(lat), 32'd17);
      check("small_act", 32'(sif.act_out), 32'hC);
      check("small_class", 32'(sif.class_out), 32'd3);
      check("small_score", 32'(sif.score_out), 32'd7);
      tick();

      // Reset in cycle 50 of a frame
      bif.data_in = dpat; bif.start = 1'b1;
      tick();
      bif.start = 1'b0;
      seen_done = 0;
      for (int i = 1; i < 50; i++) begin
         if (bif.done) seen_done++;
         tick();
      end
      check("busy_before_reset", 32'(bif.busy), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("midrst_no_done", 32'(seen_done + int'(bif.done)), 32'd0);
      check("midrst_busy", 32'(bif.busy), 32'd0);
      check("midrst_act", 32'(bif.act_out), 32'd0);
      check("midrst_class", 32'(bif.class_out), 32'd0);
      check("midrst_score", 32'(bif.score_out), 32'd0);
      check("midrst_loaded", 32'(bif.w_loaded), 32'd0);
      bif.start = 1'b1;
      for (int i = 0; i < 5; i++) tick();
      bif.start = 1'b0;
      check("start_after_reset_ignored", 32'(bif.busy), 32'd0);
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bnn_dense_engine.md
# bnn_dense_engine

Parametrised, time-multiplexed binary dense layer for the MNIST BNN datapath: XNOR-popcount of a latched binary input vector against N_OUT stored weight rows, CHUNK bits per cycle. It replaces the fixed-size hidden and final layers. One instance produces either binarised activations for the next layer or, when it is the final layer, the argmax class. Weights are loaded bit-serially from the pin interface, then frames are processed under a start/done handshake.

## Interface
- N_IN, 196: input vector width in bits.
- N_OUT, 10: neuron count.
- CHUNK, 14: input bits consumed per cycle. Must divide N_IN; an elaboration error is raised otherwise.
- THRESH, 98: activation threshold, 0..N_IN. A neuron's activation bit is 1 when acc ≥ THRESH.
- CNT_W, $clog2(N_IN+1): accumulator/score width. CW = $clog2(N_OUT), minimum 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- w_valid  in  1  serial weight bit strobe.
- w_bit  in  1  weight bit. 1 = +1, 0 = −1.
- w_loaded  out  1  all N_IN·N_OUT weight bits are present.
- start  in  1  frame request.
- data_in  in  N_IN  input vector, sampled on the accepted start.
- busy  out  1  frame in progress.
- done  out  1  one-cycle completion pulse.
- act_out  out  N_OUT  binarised activations. Bit n belongs to neuron n.
- class_out  out  CW  index of the neuron with the maximum accumulator.
- score_out  out  CNT_W  maximum accumulator value.

## Operation
- **States:** IDLE, ACC, DONE.
- **Weight load (IDLE only):**
  - Stream bit k is the weight for neuron k / N_IN, input k % N_IN (neuron 0, input 0 first).
  - Counter wcnt increments per w_valid. On reaching N_IN·N_OUT it sets w_loaded=1 and clears itself.
  - A w_valid while w_loaded=1 starts a new load: w_loaded drops the same edge and that bit becomes stream bit 0.
  - w_valid in ACC or DONE is ignored.
- **Start acceptance:** start is accepted only in IDLE with w_loaded=1. It latches data_in, clears n, c, acc, best and act, then enters ACC. Otherwise start is ignored with no side effects.
- **ACC, each cycle:**
  - acc += popcount(~(data[c·CHUNK +: CHUNK] ^ wrow_n[c·CHUNK +: CHUNK])).
  - c increments.
- **End of neuron n** (cycle with c = N_IN/CHUNK−1), using the final sum:
  - act[n] = (sum ≥ THRESH).
  - If n==0 or sum > best: best=sum, class=n. Strict compare, so ties keep the lowest index.
  - Then acc=0, c=0, n++.
  - After neuron N_OUT−1, go to DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE.
- **Output registers:** act_out, class_out and score_out update only on entry to DONE and hold until the next DONE. Intermediate values are never visible.
- **Width rules:**
  - Accumulator is CNT_W bits wide. The maximum is N_IN, so it never overflows.
  - popcount is $clog2(CHUNK+1) bits, zero-extended.

## Timing
- **Reset** (rst=1 at an edge): state=IDLE; busy=0, done=0, w_loaded=0, act_out=0, class_out=0, score_out=0; wcnt, n and c are 0. Weight storage contents are don't-care after reset and require a reload.
- **Reset mid-frame or mid-load:** abort at that edge with no done pulse. The reset values above apply from the next cycle.
- **Latency:**
  - Start is accepted at edge E0.
  - busy=1 from E0 through the cycle in which done=1.
  - ACC lasts exactly N_OUT·N_IN/CHUNK cycles.
  - done is asserted in cycle N_OUT·N_IN/CHUNK + 1 after E0. Defaults: 141.
- **Back-to-back frames:** the earliest next start acceptance is the cycle after done. A start coinciding with done is ignored.
- **Load timing:** w_loaded rises the cycle after the final w_valid. start together with that final w_valid is ignored.

## Test plan
- **All-ones weights and data**, defaults → after 141 cycles: done pulse; act_out=10'h3FF; class_out=0 (tie rule); score_out=196.
- **Neuron 3 weights = data_in; all other rows = ~data_in** → act_out=10'b0000001000, class_out=3, score_out=196. Other accumulators are 0.
- **N_IN=8, N_OUT=4, CHUNK=2, THRESH=5; row n matches data in exactly 2n+1 bits** → acc = 1, 3, 5, 7; act_out=4'b1100, class_out=3, score_out=7; done 17 cycles after start.
- **Protocol misuse:**
  - start before load completes → no busy, no done.
  - start during ACC → ignored.
  - w_valid during ACC → wcnt unchanged.
  - Results match an undisturbed run.
- **Reload:** load pattern A, run, reload pattern B → w_loaded drops on the first new bit and returns after 1960 bits; the second run reflects B only.
- **rst asserted at cycle 50 of a frame** → busy=0 and all outputs zero next cycle, no done pulse; w_loaded=0, and start is ignored until the weights are reloaded.
